// File: rtl/enemies_struct.sv
// ---------------------------------------------------------------------------
// enemies_struct
// Shared types for the enemy grid and for the blocks that interact with it.
//   enemy_t       : one grid cell (position, alive flag, identifier)
//   shot_state_e  : player-shot controller states
//   COORD_W       : screen coordinate width used across the game datapath
// ---------------------------------------------------------------------------
package enemies_struct;

  localparam int COORD_W    = 12;
  localparam int ENEMY_ID_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0]    x;
    logic [COORD_W-1:0]    y;
    logic                  alive;
    logic [ENEMY_ID_W-1:0] id;
  } enemy_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    HIT      = 2'd2,
    COOLDOWN = 2'd3
  } shot_state_e;

  // Zero-extend a coordinate so box bounds can be summed without wrapping.
  function automatic logic [COORD_W:0] coord_ext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/shot_hit_test.sv
// ---------------------------------------------------------------------------
// shot_hit_test
// Combinational point-in-box test of a point against one enemy hitbox.
// The box spans [x, x+ENEMY_WIDTH) by [y, y+ENEMY_HEIGHT); a dead enemy
// never reports a hit.
// Ports:
//   enemy   in  enemy_t  cell under test
//   shot_x  in  12       point x
//   shot_y  in  12       point y
//   hit     out 1        point lies inside the live enemy's box
// ---------------------------------------------------------------------------
module shot_hit_test
  import enemies_struct::*;
#(
  parameter int ENEMY_WIDTH  = 60,
  parameter int ENEMY_HEIGHT = 60
) (
  input  enemy_t             enemy,
  input  logic [COORD_W-1:0] shot_x,
  input  logic [COORD_W-1:0] shot_y,
  output logic               hit
);

  logic [COORD_W:0] x_lo_s;
  logic [COORD_W:0] x_hi_s;
  logic [COORD_W:0] y_lo_s;
  logic [COORD_W:0] y_hi_s;
  logic [COORD_W:0] px_s;
  logic [COORD_W:0] py_s;
  logic             unused_id_s;

  // The id field identifies the enemy but plays no part in the geometry.
  assign unused_id_s = ^enemy.id;

  // Bounds are formed one bit wider than a coordinate so the far edge never wraps.
  always_comb begin
    x_lo_s = coord_ext(enemy.x);
    y_lo_s = coord_ext(enemy.y);
    x_hi_s = coord_ext(enemy.x) + (COORD_W+1)'(ENEMY_WIDTH);
    y_hi_s = coord_ext(enemy.y) + (COORD_W+1)'(ENEMY_HEIGHT);
    px_s   = coord_ext(shot_x);
    py_s   = coord_ext(shot_y);
    hit    = enemy.alive
             && (px_s >= x_lo_s) && (px_s < x_hi_s)
             && (py_s >= y_lo_s) && (py_s < y_hi_s);
  end

endmodule

// File: rtl/player_shot_collider.sv
// ---------------------------------------------------------------------------
// player_shot_collider
// Owns the single player projectile: spawns it on fire, moves it up on
// divided frame ticks, and sweeps the enemy grid one cell per clk looking
// for a hit. A hit produces a one-cycle valid_enemy_collision pulse with the
// shot-tip coordinates, followed by a cooldown so the consumer can retire
// the enemy before another shot can be fired.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   enable                  game running; low clears everything synchronously
//   freeze                  pause: motion, scanning and cooldown hold
//   frame_rate              one-clk frame tick
//   fire                    fire request (level or pulse)
//   player_x [11:0]         player left edge
//   enemies                 enemy grid, [row][column]
//   shot_active             shot is on screen
//   shot_x, shot_y [11:0]   shot tip position
//   valid_enemy_collision   one-cycle hit pulse
//   killed_enemy_x/y [11:0] shot tip at the hit, held until the next hit
// ---------------------------------------------------------------------------
module player_shot_collider
  import enemies_struct::*;
#(
  parameter int NB_ENEMY_Y      = 10,
  parameter int NB_ENEMY_X      = 5,
  parameter int ENEMY_WIDTH     = 60,
  parameter int ENEMY_HEIGHT    = 60,
  parameter int PLAYER_WIDTH    = 40,
  parameter int SPAWN_Y         = 420,
  parameter int SHOT_STEP       = 6,
  parameter int SHOT_DIV        = 2,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               freeze,
  input  logic               frame_rate,
  input  logic               fire,
  input  logic [COORD_W-1:0] player_x,
  input  enemy_t             enemies [NB_ENEMY_Y][NB_ENEMY_X],
  output logic               shot_active,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  output logic               valid_enemy_collision,
  output logic [COORD_W-1:0] killed_enemy_x,
  output logic [COORD_W-1:0] killed_enemy_y
);

  localparam int ROW_W = (NB_ENEMY_Y > 1)      ? $clog2(NB_ENEMY_Y)      : 1;
  localparam int COL_W = (NB_ENEMY_X > 1)      ? $clog2(NB_ENEMY_X)      : 1;
  localparam int DIV_W = (SHOT_DIV > 1)        ? $clog2(SHOT_DIV)        : 1;
  localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  shot_state_e        state_r,   state_nxt_s;
  logic [ROW_W-1:0]   row_r,     row_nxt_s;
  logic [COL_W-1:0]   col_r,     col_nxt_s;
  logic [DIV_W-1:0]   div_r,     div_nxt_s;
  logic [CD_W-1:0]    cd_r,      cd_nxt_s;
  logic               active_r,  active_nxt_s;
  logic [COORD_W-1:0] sx_r,      sx_nxt_s;
  logic [COORD_W-1:0] sy_r,      sy_nxt_s;
  logic               valid_r,   valid_nxt_s;
  logic [COORD_W-1:0] kx_r,      kx_nxt_s;
  logic [COORD_W-1:0] ky_r,      ky_nxt_s;

  enemy_t             cell_s;
  logic               hit_s;
  logic               tick_s;
  logic [COORD_W:0]   spawn_sum_s;
  logic [COORD_W-1:0] spawn_x_s;

  // Cell under test this clk, selected by the sweep index.
  assign cell_s = enemies[row_r][col_r];

  shot_hit_test #(
    .ENEMY_WIDTH  (ENEMY_WIDTH),
    .ENEMY_HEIGHT (ENEMY_HEIGHT)
  ) u_hit_test (
    .enemy  (cell_s),
    .shot_x (sx_r),
    .shot_y (sy_r),
    .hit    (hit_s)
  );

  // Move tick: the SHOT_DIV-th counted frame pulse.
  assign tick_s = frame_rate && (div_r == DIV_W'(SHOT_DIV - 1));

  // Spawn at the player centre; never 0 so killed_enemy_x stays nonzero,
  // and saturate at the screen edge rather than wrapping.
  always_comb begin
    spawn_sum_s = coord_ext(player_x) + (COORD_W+1)'(PLAYER_WIDTH / 2);
    if (spawn_sum_s[COORD_W]) begin
      spawn_x_s = {COORD_W{1'b1}};
    end else if (spawn_sum_s[COORD_W-1:0] == {COORD_W{1'b0}}) begin
      spawn_x_s = COORD_W'(1);
    end else begin
      spawn_x_s = spawn_sum_s[COORD_W-1:0];
    end
  end

  // Next-state and datapath update for the shot controller.
  always_comb begin
    state_nxt_s  = state_r;
    row_nxt_s    = row_r;
    col_nxt_s    = col_r;
    div_nxt_s    = div_r;
    cd_nxt_s     = cd_r;
    active_nxt_s = active_r;
    sx_nxt_s     = sx_r;
    sy_nxt_s     = sy_r;
    valid_nxt_s  = 1'b0;
    kx_nxt_s     = kx_r;
    ky_nxt_s     = ky_r;

    case (state_r)
      IDLE: begin
        if (fire && !freeze) begin
          sx_nxt_s     = spawn_x_s;
          sy_nxt_s     = COORD_W'(SPAWN_Y);
          active_nxt_s = 1'b1;
          state_nxt_s  = FLY;
        end else begin
          state_nxt_s  = IDLE;
        end
      end

      FLY: begin
        if (!freeze) begin
          // Raster sweep: one cell per clk, column first.
          if (col_r == COL_W'(NB_ENEMY_X - 1)) begin
            col_nxt_s = {COL_W{1'b0}};
            if (row_r == ROW_W'(NB_ENEMY_Y - 1)) begin
              row_nxt_s = {ROW_W{1'b0}};
            end else begin
              row_nxt_s = row_r + ROW_W'(1);
            end
          end else begin
            col_nxt_s = col_r + COL_W'(1);
          end

          if (tick_s) begin
            div_nxt_s = {DIV_W{1'b0}};
          end else if (frame_rate) begin
            div_nxt_s = div_r + DIV_W'(1);
          end else begin
            div_nxt_s = div_r;
          end

          // A hit takes priority over a coincident move so the reported
          // coordinates are exactly where the collision was seen.
          if (hit_s) begin
            kx_nxt_s    = sx_r;
            ky_nxt_s    = sy_r;
            valid_nxt_s = 1'b1;
            state_nxt_s = HIT;
          end else if (tick_s) begin
            if (sy_r <= COORD_W'(SHOT_STEP)) begin
              active_nxt_s = 1'b0;
              state_nxt_s  = IDLE;
            end else begin
              sy_nxt_s     = sy_r - COORD_W'(SHOT_STEP);
            end
          end else begin
            state_nxt_s = FLY;
          end
        end else begin
          state_nxt_s = FLY;
        end
      end

      // The pulse is already on the output; it completes even under freeze.
      HIT: begin
        active_nxt_s = 1'b0;
        cd_nxt_s     = {CD_W{1'b0}};
        state_nxt_s  = COOLDOWN;
      end

      // Gives the consumer time to clear the alive flag before a new shot.
      COOLDOWN: begin
        if (!freeze) begin
          if (cd_r == CD_W'(COOLDOWN_CYCLES - 1)) begin
            cd_nxt_s    = {CD_W{1'b0}};
            state_nxt_s = IDLE;
          end else begin
            cd_nxt_s    = cd_r + CD_W'(1);
          end
        end else begin
          cd_nxt_s = cd_r;
        end
      end

      default: begin
        active_nxt_s = 1'b0;
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // State and output registers; enable low drops the shot synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      row_r    <= {ROW_W{1'b0}};
      col_r    <= {COL_W{1'b0}};
      div_r    <= {DIV_W{1'b0}};
      cd_r     <= {CD_W{1'b0}};
      active_r <= 1'b0;
      sx_r     <= {COORD_W{1'b0}};
      sy_r     <= {COORD_W{1'b0}};
      valid_r  <= 1'b0;
      kx_r     <= {COORD_W{1'b0}};
      ky_r     <= {COORD_W{1'b0}};
    end else if (!enable) begin
      state_r  <= IDLE;
      row_r    <= {ROW_W{1'b0}};
      col_r    <= {COL_W{1'b0}};
      div_r    <= {DIV_W{1'b0}};
      cd_r     <= {CD_W{1'b0}};
      active_r <= 1'b0;
      sx_r     <= {COORD_W{1'b0}};
      sy_r     <= {COORD_W{1'b0}};
      valid_r  <= 1'b0;
      kx_r     <= {COORD_W{1'b0}};
      ky_r     <= {COORD_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      row_r    <= row_nxt_s;
      col_r    <= col_nxt_s;
      div_r    <= div_nxt_s;
      cd_r     <= cd_nxt_s;
      active_r <= active_nxt_s;
      sx_r     <= sx_nxt_s;
      sy_r     <= sy_nxt_s;
      valid_r  <= valid_nxt_s;
      kx_r     <= kx_nxt_s;
      ky_r     <= ky_nxt_s;
    end
  end

  assign shot_active           = active_r;
  assign shot_x                = sx_r;
  assign shot_y                = sy_r;
  assign valid_enemy_collision = valid_r;
  assign killed_enemy_x        = kx_r;
  assign killed_enemy_y        = ky_r;

endmodule

// File: tb/tb_player_shot_collider.sv
// ---------------------------------------------------------------------------
// tb_player_shot_collider
// Self-checking bench: expected hit coordinates are queued when a hit
// scenario is set up and popped when the collision pulse appears.
// ---------------------------------------------------------------------------
module tb_player_shot_collider;
  import enemies_struct::*;

  localparam int NY = 10;
  localparam int NX = 5;

  logic        clk = 1'b0;
  logic        rst_n, enable, freeze, frame_rate, fire;
  logic [11:0] player_x;
  enemy_t      enemies [NY][NX];
  logic        shot_active, valid_enemy_collision;
  logic [11:0] shot_x, shot_y, killed_enemy_x, killed_enemy_y;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
  } kill_t;

  kill_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    pulse_cnt  = 0;
  int    consec_cnt = 0;
  logic  prev_valid = 1'b0;

  always #5 clk = ~clk;

  player_shot_collider dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .enable                (enable),
    .freeze                (freeze),
    .frame_rate            (frame_rate),
    .fire                  (fire),
    .player_x              (player_x),
    .enemies               (enemies),
    .shot_active           (shot_active),
    .shot_x                (shot_x),
    .shot_y                (shot_y),
    .valid_enemy_collision (valid_enemy_collision),
    .killed_enemy_x        (killed_enemy_x),
    .killed_enemy_y        (killed_enemy_y)
  );

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_enemy_collision) begin
      pulse_cnt <= pulse_cnt + 1;
      if (prev_valid) consec_cnt <= consec_cnt + 1;
    end
    prev_valid <= valid_enemy_collision;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_rate = 1'b1;
    step();
    frame_rate = 1'b0;
    step();
  endtask

  task automatic set_grid(input logic alive);
    for (int r = 0; r < NY; r++) begin
      for (int c = 0; c < NX; c++) begin
        enemies[r][c].x     = 12'd75;
        enemies[r][c].y     = 12'd65;
        enemies[r][c].alive = alive;
        enemies[r][c].id    = 8'(r * NX + c);
      end
    end
  endtask

  task automatic do_clear();
    fire = 1'b0; frame_rate = 1'b0; freeze = 1'b0; enable = 1'b0;
    step(); step();
    enable = 1'b1;
    step();
  endtask

  // Spawn from player_x=100 and fly up to target_y (even pulse count: divider 0).
  task automatic fly_to(input logic [11:0] target_y);
    player_x = 12'd100;
    fire = 1'b1;
    step();
    fire = 1'b0;
    for (int i = 0; i < 300 && shot_y !== target_y; i++) begin
      frame_pulse(); frame_pulse();
    end
    n_tests++;
    if (shot_y !== target_y) begin
      n_fail++;
      $display("FAIL fly_to: shot_y=%0d expected %0d", shot_y, target_y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; freeze = 1'b0; frame_rate = 1'b0; fire = 1'b0;
    player_x = 12'd0;
    set_grid(1'b0);
    step(); step();
    n_tests++;
    if ({shot_active, valid_enemy_collision, shot_x, shot_y, killed_enemy_x, killed_enemy_y} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: act=%0b v=%0b x=%0d y=%0d kx=%0d ky=%0d", shot_active,
               valid_enemy_collision, shot_x, shot_y, killed_enemy_x, killed_enemy_y);
    end
    rst_n = 1'b1;
    step();
    player_x = 12'd100;
    fire = 1'b1;
    step();
    fire = 1'b0;
    n_tests++;
    if (shot_active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_spawn: shot_active=%0b expected 1", shot_active);
    end
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (shot_active !== 1'b0 || shot_y !== 12'd0) begin
      n_fail++;
      $display("FAIL async_reset: shot_active=%0b shot_y=%0d expected 0/0", shot_active, shot_y);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_spawn();
    do_clear();
    player_x = 12'd100;
    fire = 1'b1;
    step();
    fire = 1'b0;
    n_tests++;
    if (shot_active !== 1'b1 || shot_x !== 12'd120 || shot_y !== 12'd420) begin
      n_fail++;
      $display("FAIL spawn: act=%0b x=%0d y=%0d expected 1/120/420", shot_active, shot_x, shot_y);
    end
    frame_pulse();
    n_tests++;
    if (shot_y !== 12'd420) begin
      n_fail++;
      $display("FAIL first_pulse: shot_y=%0d expected 420", shot_y);
    end
    frame_pulse();
    n_tests++;
    if (shot_y !== 12'd414) begin
      n_fail++;
      $display("FAIL second_pulse: shot_y=%0d expected 414", shot_y);
    end
    frame_pulse(); frame_pulse();
    n_tests++;
    if (shot_y !== 12'd408 || shot_x !== 12'd120) begin
      n_fail++;
      $display("FAIL fourth_pulse: x=%0d y=%0d expected 120/408", shot_x, shot_y);
    end
  endtask

  task automatic test_hit();
    int   p0;
    bit   found;
    kill_t k;
    do_clear();
    set_grid(1'b0);
    p0 = pulse_cnt;
    fly_to(12'd120);
    n_tests++;
    if (pulse_cnt != p0) begin
      n_fail++;
      $display("FAIL hit_dead_fly: pulses=%0d expected 0", pulse_cnt - p0);
    end
    enemies[0][0].alive = 1'b1;
    exp_q.push_back('{x: 12'd120, y: 12'd120});
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (valid_enemy_collision === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL hit_timeout: no pulse within 60 clk, expected one");
      void'(exp_q.pop_front());
    end else begin
      k = exp_q.pop_front();
      if (killed_enemy_x !== k.x || killed_enemy_y !== k.y) begin
        n_fail++;
        $display("FAIL hit_coords: killed=(%0d,%0d) expected (%0d,%0d)",
                 killed_enemy_x, killed_enemy_y, k.x, k.y);
      end
      step();
      n_tests++;
      if (valid_enemy_collision !== 1'b0 || shot_active !== 1'b0 ||
          killed_enemy_x !== k.x || killed_enemy_y !== k.y) begin
        n_fail++;
        $display("FAIL hit_after1: v=%0b act=%0b killed=(%0d,%0d) expected 0/0/(%0d,%0d)",
                 valid_enemy_collision, shot_active, killed_enemy_x, killed_enemy_y, k.x, k.y);
      end
      step();
      n_tests++;
      if (killed_enemy_x !== k.x || killed_enemy_y !== k.y) begin
        n_fail++;
        $display("FAIL hit_hold2: killed=(%0d,%0d) expected (%0d,%0d)",
                 killed_enemy_x, killed_enemy_y, k.x, k.y);
      end
      step();
      fire = 1'b1;
      step();
      fire = 1'b0;
      n_tests++;
      if (shot_active !== 1'b0) begin
        n_fail++;
        $display("FAIL cooldown_fire3: shot_active=%0b expected 0", shot_active);
      end
      step();
      fire = 1'b1;
      step();
      fire = 1'b0;
      n_tests++;
      if (shot_active !== 1'b1 || shot_y !== 12'd420) begin
        n_fail++;
        $display("FAIL cooldown_fire5: act=%0b y=%0d expected 1/420", shot_active, shot_y);
      end
    end
    enemies[0][0].alive = 1'b0;
  endtask

  task automatic test_dead_enemy();
    int          p0;
    logic [11:0] exp_y;
    logic        exp_act;
    do_clear();
    set_grid(1'b0);
    p0 = pulse_cnt;
    player_x = 12'd100;
    fire = 1'b1;
    step();
    fire = 1'b0;
    exp_y = 12'd420;
    exp_act = 1'b1;
    for (int i = 0; i < 71; i++) begin
      frame_pulse(); frame_pulse();
      if (exp_y <= 12'd6) exp_act = 1'b0;
      else exp_y = exp_y - 12'd6;
      n_tests++;
      if (shot_active !== exp_act || (exp_act && shot_y !== exp_y)) begin
        n_fail++;
        $display("FAIL dead_fly[%0d]: act=%0b y=%0d expected %0b/%0d", i, shot_active, shot_y,
                 exp_act, exp_y);
      end
    end
    n_tests++;
    if (pulse_cnt != p0) begin
      n_fail++;
      $display("FAIL dead_pulse: pulses=%0d expected 0", pulse_cnt - p0);
    end
    fire = 1'b1;
    step();
    fire = 1'b0;
    n_tests++;
    if (shot_active !== 1'b1 || shot_y !== 12'd420) begin
      n_fail++;
      $display("FAIL dead_refire: act=%0b y=%0d expected 1/420", shot_active, shot_y);
    end
  endtask

  task automatic test_simultaneous();
    kill_t k;
    do_clear();
    set_grid(1'b0);
    fly_to(12'd120);
    frame_pulse();
    set_grid(1'b1);
    frame_rate = 1'b1;
    exp_q.push_back('{x: 12'd120, y: 12'd120});
    step();
    frame_rate = 1'b0;
    k = exp_q.pop_front();
    n_tests++;
    if (valid_enemy_collision !== 1'b1 || killed_enemy_x !== k.x || killed_enemy_y !== k.y ||
        shot_y !== 12'd120) begin
      n_fail++;
      $display("FAIL simul: v=%0b killed=(%0d,%0d) y=%0d expected 1/(%0d,%0d)/120",
               valid_enemy_collision, killed_enemy_x, killed_enemy_y, shot_y, k.x, k.y);
    end
    step();
    n_tests++;
    if (valid_enemy_collision !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_width: valid=%0b expected 0", valid_enemy_collision);
    end
    set_grid(1'b0);
  endtask

  task automatic test_freeze();
    int p0;
    do_clear();
    set_grid(1'b0);
    p0 = pulse_cnt;
    player_x = 12'd100;
    fire = 1'b1;
    step();
    fire = 1'b0;
    frame_pulse();
    freeze = 1'b1;
    for (int i = 0; i < 100; i++) frame_pulse();
    n_tests++;
    if (shot_y !== 12'd420 || shot_active !== 1'b1 || pulse_cnt != p0) begin
      n_fail++;
      $display("FAIL freeze_hold: y=%0d act=%0b pulses=%0d expected 420/1/0", shot_y,
               shot_active, pulse_cnt - p0);
    end
    freeze = 1'b0;
    step();
    frame_pulse();
    n_tests++;
    if (shot_y !== 12'd414) begin
      n_fail++;
      $display("FAIL freeze_resume: shot_y=%0d expected 414", shot_y);
    end
  endtask

  task automatic test_enable();
    int p0;
    do_clear();
    set_grid(1'b0);
    p0 = pulse_cnt;
    fly_to(12'd120);
    set_grid(1'b1);
    enable = 1'b0;
    step();
    n_tests++;
    if (shot_active !== 1'b0 || shot_x !== 12'd0 || shot_y !== 12'd0) begin
      n_fail++;
      $display("FAIL enable_drop: act=%0b x=%0d y=%0d expected 0/0/0", shot_active, shot_x, shot_y);
    end
    step(); step();
    set_grid(1'b0);
    enable = 1'b1;
    step();
    n_tests++;
    if (pulse_cnt != p0) begin
      n_fail++;
      $display("FAIL enable_pulse: pulses=%0d expected 0", pulse_cnt - p0);
    end
    player_x = 12'd200;
    fire = 1'b1;
    step();
    fire = 1'b0;
    n_tests++;
    if (shot_active !== 1'b1 || shot_x !== 12'd220 || shot_y !== 12'd420) begin
      n_fail++;
      $display("FAIL enable_refire: act=%0b x=%0d y=%0d expected 1/220/420", shot_active,
               shot_x, shot_y);
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_hit();
    test_dead_enemy();
    test_simultaneous();
    test_freeze();
    test_enable();
    step(); step();
    n_tests++;
    if (consec_cnt != 0 || pulse_cnt != 2) begin
      n_fail++;
      $display("FAIL pulse_totals: pulses=%0d consecutive=%0d expected 2/0", pulse_cnt, consec_cnt);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
